of_scoreboard: RTL and testbench
================================

Name: of_scoreboard

Overview:
Register-hazard scoreboard and issue controller for the operand fetch stage of the 32-bit, 16-register RISC pipeline. It sequences operand fetch and blocks issue until a source register's in-flight writes have retired.
- Tracks the number of pending writes per architectural register.
- Gates hand-off of the decoded instruction to execute.
- Source selection is done upstream: ret forces rs1 = r15; st routes rd onto rs2.
- Also provides stall statistics and an error flag for bookkeeping faults.

Parameters:
NREG, 16, number of architectural registers (index width = clog2(NREG) = 4)
CNT_W, 2, width of each pending-write counter; max in-flight writes per register = 2^CNT_W-1
WB_BYPASS, 1, 1 = a source whose last pending write retires this cycle is not a hazard; 0 = wait one extra cycle

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
of_valid  input  1  decoded instruction present in operand fetch
of_rs1  input  4  first source register index
of_rs1_en  input  1  instruction reads of_rs1
of_rs2  input  4  second source register index
of_rs2_en  input  1  instruction reads of_rs2
of_rd  input  4  destination register index
of_rd_en  input  1  instruction writes of_rd
ex_ready  input  1  execute stage can accept an instruction this cycle
wb_valid  input  1  a register write retires this cycle
wb_rd  input  4  register written by the retiring instruction
flush  input  1  pipeline flush (branch taken / ret); kills all in-flight instructions
of_issue  output  1  instruction handed to execute this cycle (combinational)
of_stall  output  1  of_valid & ~of_issue (combinational)
busy_vec  output  16  bit r = 1 when cnt[r] != 0 (registered view)
stall_cycles  output  16  saturating count of cycles with of_stall = 1
sb_err  output  1  sticky; writeback to a register with no pending write

Behaviour:
- Reset (synchronous, highest priority): all cnt[r] = 0, state = RUN, stall_cycles = 0, sb_err = 0. Hence busy_vec = 0, of_issue = 0, of_stall = 0 while of_valid = 0.
- Pending test: pend(r) = (cnt[r] != 0) & ~(WB_BYPASS & wb_valid & wb_rd == r & cnt[r] == 1).
- Hazard: (of_rs1_en & pend(of_rs1)) | (of_rs2_en & pend(of_rs2)) | (of_rd_en & cnt[of_rd] == max). The last term is the structural stall on counter saturation.
- WAW is allowed below saturation, because writeback is in order.
- of_issue = of_valid & ex_ready & ~hazard & (state != FLUSH) & ~flush.
- FSM states: RUN, STALL, FLUSH.
  - RUN -> STALL when of_valid & ~of_issue.
  - STALL -> RUN on of_issue.
  - STALL stays STALL while of_valid & ~of_issue.
  - STALL -> RUN if of_valid drops.
  - Any state -> FLUSH when flush = 1.
  - FLUSH -> RUN after exactly one cycle, unless flush is still asserted.
- Counter update, per edge, when not reset and not flush:
  - inc = of_issue & of_rd_en on of_rd.
  - dec = wb_valid on wb_rd.
  - inc and dec on the same register in the same cycle: no change.
  - dec with cnt = 0: counter stays 0 and sb_err is set.
  - Counters never wrap.
- Flush cycle:
  - All counters cleared to 0.
  - No issue.
  - wb_valid is ignored: no decrement, no sb_err.
  - The killed instructions produce no later writebacks.
- FLUSH state cycle: normal counter rules apply; issue is still blocked.
- stall_cycles increments on every edge with of_stall = 1 and holds at 0xFFFF.
- sb_err is cleared only by reset.
- Latency:
  - A dependent instruction issues in the same cycle its producer's writeback is presented (WB_BYPASS = 1), or the following cycle (WB_BYPASS = 0).
  - An independent instruction issues with zero added latency.
- Register r0 is tracked like any other register (no hardwired zero).

Test Plan:
- Reset, then of_valid=1, rs1=3, rs2=4, rd=5, ex_ready=1 -> of_issue=1 same cycle; next cycle busy_vec=0x0020.
- RAW: issue write to r5, then instruction reading rs1=5 -> of_stall=1, state STALL, stall_cycles counts 1,2,...; wb_valid with wb_rd=5 -> of_issue=1 that cycle (WB_BYPASS=1), or one cycle later with WB_BYPASS=0.
- Saturation: three issues with rd=7 and no writeback -> cnt[7]=3; a fourth rd=7 instruction stalls; one wb_rd=7 -> it issues next cycle.
- Simultaneous events: issue rd=2 while wb_rd=2 retires with cnt[2]=1 -> cnt[2] stays 1 and busy_vec[2] stays 1.
- Flush with cnt[5]=2 and wb_valid=1 on the same edge -> all counters 0, sb_err=0, of_issue=0 for that cycle and the FLUSH cycle, issue resumes the following cycle.
- Error and reset: wb_valid with wb_rd=9 and cnt[9]=0 -> sb_err=1 and stays 1; reset asserted mid-stall -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/of_scoreboard.sv
// Register-hazard scoreboard for operand fetch: per-register pending-write counters gate issue to execute.
// Issue is combinational (zero added latency); stalls on RAW hazard, counter saturation, !ex_ready or flush.
module of_scoreboard #(
  parameter int NREG      = 16,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 1,
  localparam int IW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            of_valid,
  input  logic [IW-1:0]   of_rs1,
  input  logic            of_rs1_en,
  input  logic [IW-1:0]   of_rs2,
  input  logic            of_rs2_en,
  input  logic [IW-1:0]   of_rd,
  input  logic            of_rd_en,
  input  logic            ex_ready,
  input  logic            wb_valid,
  input  logic [IW-1:0]   wb_rd,
  input  logic            flush,
  output logic            of_issue,
  output logic            of_stall,
  output logic [NREG-1:0] busy_vec,
  output logic [15:0]     stall_cycles,
  output logic            sb_err
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic             BYPASS  = (WB_BYPASS != 0);

  state_t           state;
  logic [CNT_W-1:0] cnt [NREG];
  logic             pend1, pend2, sat, hazard;
  logic [NREG-1:0]  inc_vec, dec_vec;

  // A source whose only pending write retires this cycle is treated as ready when bypass is on.
  always_comb begin
    pend1  = (cnt[of_rs1] != '0) &
             ~(BYPASS & wb_valid & (wb_rd == of_rs1) & (cnt[of_rs1] == CNT_ONE));
    pend2  = (cnt[of_rs2] != '0) &
             ~(BYPASS & wb_valid & (wb_rd == of_rs2) & (cnt[of_rs2] == CNT_ONE));
    sat    = (cnt[of_rd] == CNT_MAX);
    hazard = (of_rs1_en & pend1) | (of_rs2_en & pend2) | (of_rd_en & sat);
  end

  assign of_issue = of_valid & ex_ready & ~hazard & (state != FLUSH) & ~flush;
  assign of_stall = of_valid & ~of_issue;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (of_issue && of_rd_en) inc_vec[of_rd] = 1'b1;
    if (wb_valid) dec_vec[wb_rd] = 1'b1;
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt[r] != '0);
  end

  // Flush discards in-flight work, so its concurrent writeback is dropped without error.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      sb_err <= 1'b0;
    end else if (flush) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc_vec[r] && !dec_vec[r]) begin
          if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec_vec[r] && !inc_vec[r]) begin
          if (cnt[r] == '0) sb_err <= 1'b1;
          else              cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      stall_cycles <= '0;
    end else begin
      if (of_stall && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (flush) begin
        state <= FLUSH;
      end else begin
        case (state)
          RUN:     state <= of_stall ? STALL : RUN;
          STALL:   state <= of_stall ? STALL : RUN;
          FLUSH:   state <= RUN;
          default: state <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_of_scoreboard.sv
// Directed-vector bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_of_scoreboard;

  logic        clk = 1'b0;
  logic        reset, of_valid, of_rs1_en, of_rs2_en, of_rd_en, ex_ready, wb_valid, flush;
  logic [3:0]  of_rs1, of_rs2, of_rd, wb_rd;
  logic        of_issue, of_stall, sb_err;
  logic [15:0] busy_vec, stall_cycles;

  typedef struct {
    int          idx;
    logic        issue;
    logic        stall;
    logic [15:0] busy;
    logic [15:0] sc;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  always #5 clk = ~clk;

  of_scoreboard #(.NREG(16), .CNT_W(2), .WB_BYPASS(1)) dut (
    .clk(clk), .reset(reset), .of_valid(of_valid),
    .of_rs1(of_rs1), .of_rs1_en(of_rs1_en), .of_rs2(of_rs2), .of_rs2_en(of_rs2_en),
    .of_rd(of_rd), .of_rd_en(of_rd_en), .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .of_issue(of_issue), .of_stall(of_stall), .busy_vec(busy_vec),
    .stall_cycles(stall_cycles), .sb_err(sb_err)
  );

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("of_issue",     e.idx, {15'd0, of_issue}, {15'd0, e.issue});
      chk("of_stall",     e.idx, {15'd0, of_stall}, {15'd0, e.stall});
      chk("busy_vec",     e.idx, busy_vec,          e.busy);
      chk("stall_cycles", e.idx, stall_cycles,      e.sc);
      chk("sb_err",       e.idx, {15'd0, sb_err},   {15'd0, e.err});
    end
  end

  // Drive one cycle of inputs and queue what the outputs must show during that cycle.
  task automatic step(input logic rst, fl, v, input logic [3:0] rs1, input logic e1,
                      input logic [3:0] rs2, input logic e2, input logic [3:0] rd, input logic ed,
                      input logic exr, wbv, input logic [3:0] wbrd,
                      input logic ei, es, input logic [15:0] eb, esc, input logic ee);
    exp_t e;
    reset = rst; flush = fl; of_valid = v;
    of_rs1 = rs1; of_rs1_en = e1; of_rs2 = rs2; of_rs2_en = e2;
    of_rd = rd; of_rd_en = ed; ex_ready = exr; wb_valid = wbv; wb_rd = wbrd;
    step_no++;
    e.idx = step_no; e.issue = ei; e.stall = es; e.busy = eb; e.sc = esc; e.err = ee;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; of_valid = 1'b0; ex_ready = 1'b0; wb_valid = 1'b0;
    of_rs1 = '0; of_rs2 = '0; of_rd = '0; wb_rd = '0;
    of_rs1_en = 1'b0; of_rs2_en = 1'b0; of_rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    //    rst fl v  rs1 e1 rs2 e2 rd  ed exr wbv wbrd  iss stl busy      sc     err
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0000, 16'd0, 0); // reset state
    step(0, 0, 1, 3, 1, 4, 1, 5, 1, 1, 0, 0,   1, 0, 16'h0000, 16'd0, 0); // independent issue
    step(0, 0, 1, 5, 1, 0, 0, 6, 1, 1, 0, 0,   0, 1, 16'h0020, 16'd0, 0); // RAW on r5
    step(0, 0, 1, 5, 1, 0, 0, 6, 1, 1, 0, 0,   0, 1, 16'h0020, 16'd1, 0);
    step(0, 0, 1, 5, 1, 0, 0, 6, 1, 1, 1, 5,   1, 0, 16'h0020, 16'd2, 0); // bypass issue
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0040, 16'd2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6,   0, 0, 16'h0040, 16'd2, 0);
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 16'h0000, 16'd2, 0); // saturate r7
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 16'h0080, 16'd2, 0);
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 16'h0080, 16'd2, 0);
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   0, 1, 16'h0080, 16'd2, 0);
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 1, 7,   0, 1, 16'h0080, 16'd3, 0);
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 0, 0,   1, 0, 16'h0080, 16'd4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 16'h0080, 16'd4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 16'h0080, 16'd4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 16'h0080, 16'd4, 0);
    step(0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 0, 0,   1, 0, 16'h0000, 16'd4, 0); // inc+dec same reg
    step(0, 0, 1, 0, 0, 0, 0, 2, 1, 1, 1, 2,   1, 0, 16'h0004, 16'd4, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0004, 16'd4, 0);
    step(0, 0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0,   1, 0, 16'h0004, 16'd4, 0); // r5 to 2
    step(0, 0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0,   1, 0, 16'h0024, 16'd4, 0);
    step(0, 1, 1, 0, 0, 0, 0, 8, 1, 1, 1, 5,   0, 1, 16'h0024, 16'd4, 0); // flush + wb
    step(0, 0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0,   0, 1, 16'h0000, 16'd5, 0); // FLUSH state
    step(0, 0, 1, 0, 0, 0, 0, 8, 1, 1, 0, 0,   1, 0, 16'h0000, 16'd6, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0100, 16'd6, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8,   0, 0, 16'h0100, 16'd6, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 16'h0000, 16'd6, 0); // wb with no pending
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0000, 16'd6, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0000, 16'd6, 1);
    step(0, 0, 1, 0, 0, 0, 0, 10, 1, 1, 0, 0,  1, 0, 16'h0000, 16'd6, 1);
    step(0, 0, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 16'h0400, 16'd6, 1);
    step(1, 0, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0,  0, 1, 16'h0400, 16'd7, 1); // reset mid-stall
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0000, 16'd0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,   0, 1, 16'h0000, 16'd0, 0); // !ex_ready
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 16'h0000, 16'd1, 0); // r0 tracked
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0001, 16'd1, 0);
    step(0, 0, 1, 0, 0, 0, 1, 3, 0, 1, 0, 0,   0, 1, 16'h0001, 16'd1, 0); // rs2 hazard on r0
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 16'h0001, 16'd2, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 16'h0000, 16'd2, 0);
    @(negedge clk);
    #1;
    chk("queue_drained", 0, 16'(q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
